// File: rtl/wf_rr_arbiter_pkg.sv
// Shared constants, wavefront-id type and mod-40 arithmetic for the wavefront arbiter.
package wf_rr_arbiter_pkg;

    localparam int NUM_WF = 40;
    localparam int WFID_W = 6;

    typedef logic [WFID_W-1:0] wfid_t;

    // Both operands are below NUM_WF, so a single conditional subtract is enough.
    function automatic wfid_t wf_add(input wfid_t a, input wfid_t b);
        logic [WFID_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= (WFID_W+1)'(NUM_WF)) begin
            sum = sum - (WFID_W+1)'(NUM_WF);
        end
        return sum[WFID_W-1:0];
    endfunction

endpackage

// File: rtl/priority_encoder_40to6.sv
// Lowest-index-wins encoder over the 40 wavefront slots.
module priority_encoder_40to6
    import wf_rr_arbiter_pkg::*;
(
    input  logic [NUM_WF-1:0] req,
    input  logic              enable,
    output wfid_t             idx,
    output logic              valid
);

    always_comb begin
        idx = '0;
        for (int i = NUM_WF - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = wfid_t'(i);
            end
        end
        valid = enable & (|req);
    end

endmodule

// File: rtl/wf_rr_arbiter.sv
// Round-robin wavefront selector feeding the issue stage through a registered valid/ready grant.
// Rotating priority is built only when WF_RR_ARBITER_ROUND_ROBIN_EN is defined; otherwise lowest index wins.
module wf_rr_arbiter
    import wf_rr_arbiter_pkg::*;
#(
    parameter int START_WF = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_WF-1:0] wf_ready,
    input  logic              arb_enable,
    input  logic              flush,
    output logic              grant_valid,
    output wfid_t             grant_wfid,
    input  logic              grant_ready
);

    if (START_WF < 0 || START_WF >= NUM_WF) begin : g_bad_start
        $error("wf_rr_arbiter: START_WF must be in 0..39");
    end

    logic              accept;
    logic [NUM_WF-1:0] accept_mask;
    logic [NUM_WF-1:0] req_m;
    logic [NUM_WF-1:0] rot;
    wfid_t             start;
    wfid_t             idx;
    logic              enc_valid;
    wfid_t             wfid_n;
    logic              capture;

    assign accept = grant_valid & grant_ready;

    // Upstream drops the granted bit one cycle late; hide it during the accept cycle.
    assign accept_mask = accept ? (NUM_WF'(1) << grant_wfid) : '0;
    assign req_m       = wf_ready & ~accept_mask;

`ifdef WF_RR_ARBITER_ROUND_ROBIN_EN
    localparam wfid_t LAST_PTR_RST = wfid_t'((START_WF + NUM_WF - 1) % NUM_WF);

    wfid_t last_ptr;

    assign start = wf_add(last_ptr, wfid_t'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            last_ptr <= LAST_PTR_RST;
        end else if (accept) begin
            last_ptr <= grant_wfid;
        end
    end
`else
    assign start = '0;
`endif

    genvar i;
    for (i = 0; i < NUM_WF; i++) begin : g_rot
        assign rot[i] = req_m[wf_add(wfid_t'(i), start)];
    end

    priority_encoder_40to6 u_enc (
        .req    (rot),
        .enable (arb_enable),
        .idx    (idx),
        .valid  (enc_valid)
    );

    assign wfid_n  = wf_add(idx, start);
    assign capture = (!grant_valid || accept) && !flush && enc_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_valid <= 1'b0;
            grant_wfid  <= '0;
        end else if (capture) begin
            grant_valid <= 1'b1;
            grant_wfid  <= wfid_n;
        end else if (accept || flush) begin
            grant_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wf_rr_arbiter.sv
// Scoreboard bench for wf_rr_arbiter: expected accepted wfids are queued by the stimulus and popped by a monitor.
module tb_wf_rr_arbiter;

`ifdef WF_RR_ARBITER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [39:0] wf_ready;
    logic        arb_enable;
    logic        flush;
    logic        grant_valid;
    logic [5:0]  grant_wfid;
    logic        grant_ready;

    int checks = 0;
    int errors = 0;
    bit auto_clear = 1'b0;
    int exp_q[$];

    wf_rr_arbiter #(.START_WF(0)) dut (
        .clk         (clk),
        .rst         (rst),
        .wf_ready    (wf_ready),
        .arb_enable  (arb_enable),
        .flush       (flush),
        .grant_valid (grant_valid),
        .grant_wfid  (grant_wfid),
        .grant_ready (grant_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        grant_ready = 1'b0;
        flush = 1'b0;
        auto_clear = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: timeout with %0d grants outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        grant_ready = 1'b0;
    endtask

    // Monitor: every accepted grant must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && grant_valid && grant_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_grant", int'(grant_wfid), -1);
            end else begin
                check("grant_wfid", int'(grant_wfid), exp_q.pop_front());
            end
        end
    end

    // Upstream model: clear the accepted bit one cycle after the accept.
    always @(posedge clk) begin
        if (auto_clear && !rst && grant_valid && grant_ready) begin
            automatic int w = int'(grant_wfid);
            #2 wf_ready[w] = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        wf_ready = '0;
        arb_enable = 1'b1;
        flush = 1'b0;
        grant_ready = 1'b0;
        tick();
        tick();
        check("reset_valid", int'(grant_valid), 0);
        check("reset_wfid", int'(grant_wfid), 0);

        // Two requests, upstream clears after accept: grants 0 then 2, no duplicates.
        do_reset();
        auto_clear = 1'b1;
        wf_ready = 40'h00_0000_0005;
        grant_ready = 1'b1;
        exp_q.push_back(0);
        exp_q.push_back(2);
        drain("two_req_drain");
        check("two_req_idle", int'(grant_valid), 0);
        tick();
        tick();
        check("two_req_no_dup", int'(grant_valid), 0);

        // All slots ready, continuous accept, no upstream clearing.
        do_reset();
        wf_ready = '1;
        for (int k = 0; k < 45; k++) exp_q.push_back(RR ? (k % 40) : (k % 2));
        grant_ready = 1'b1;
        drain("all_ready_drain");

        // Hold grant 7 while wf_ready churns.
        do_reset();
        wf_ready = (40'd1 << 7) | (40'd1 << 20);
        tick();
        for (int k = 0; k < 5; k++) begin
            wf_ready = (k % 2 == 0) ? (40'd1 << 20) : 40'h0;
            tick();
            check("hold_valid", int'(grant_valid), 1);
            check("hold_wfid", int'(grant_wfid), 7);
        end
        auto_clear = 1'b1;
        wf_ready = 40'd1 << 7;
        grant_ready = 1'b1;
        exp_q.push_back(7);
        tick();
        wf_ready = (40'd1 << 3) | (40'd1 << 9);
        exp_q.push_back(RR ? 9 : 3);
        exp_q.push_back(RR ? 3 : 9);
        drain("hold_drain");

        // Flush together with accept of 12.
        do_reset();
        auto_clear = 1'b1;
        wf_ready = (40'd1 << 12) | (40'd1 << 14);
        tick();
        check("flush_pre_wfid", int'(grant_wfid), 12);
        flush = 1'b1;
        grant_ready = 1'b1;
        exp_q.push_back(12);
        tick();
        flush = 1'b0;
        grant_ready = 1'b0;
        check("flush_valid", int'(grant_valid), 0);
        check("flush_q_empty", exp_q.size(), 0);
        wf_ready = (40'd1 << 3) | (40'd1 << 13) | (40'd1 << 14);
        tick();
        check("flush_next_valid", int'(grant_valid), 1);
        check("flush_next_wfid", int'(grant_wfid), RR ? 13 : 3);

        // arb_enable low blocks capture; re-enable grants next cycle.
        do_reset();
        arb_enable = 1'b0;
        wf_ready = 40'd1 << 5;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("disabled_valid", int'(grant_valid), 0);
        end
        arb_enable = 1'b1;
        tick();
        check("enable_valid", int'(grant_valid), 1);
        check("enable_wfid", int'(grant_wfid), 5);
        auto_clear = 1'b1;
        grant_ready = 1'b1;
        exp_q.push_back(5);
        tick();
        grant_ready = 1'b0;
        wf_ready = (40'd1 << 2) | (40'd1 << 30);
        tick();
        check("ptr5_wfid", int'(grant_wfid), RR ? 30 : 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midreset_valid", int'(grant_valid), 0);
        check("midreset_wfid", int'(grant_wfid), 0);
        tick();
        check("post_reset_valid", int'(grant_valid), 1);
        check("post_reset_wfid", int'(grant_wfid), 2);

        // Bits 3 and 30 held, continuous accept: accept-cycle mask alternates them.
        do_reset();
        wf_ready = (40'd1 << 3) | (40'd1 << 30);
        for (int k = 0; k < 6; k++) exp_q.push_back((k % 2 == 0) ? 3 : 30);
        grant_ready = 1'b1;
        drain("alternate_drain");
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wf_rr_arbiter.md
# wf_rr_arbiter

Round-robin wavefront selector for the 40-slot wavefront pool; sits directly upstream of the issue stage. Each cycle it rotates the 40-bit per-wavefront ready vector so the slot after the last accepted grant has highest priority. It resolves the rotated vector with the 40-to-6 priority encoder and registers the winning wavefront id behind a valid/ready handshake. The grant holds stable until the issue stage accepts it.

## Interface
- `START_WF`, default 0: slot with highest priority after reset; legal range 0..39.
- `clk`  in  1  — clock; all state updates on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `wf_ready`  in  40  — level per-wavefront request; bit i = wavefront i is issuable.
- `arb_enable`  in  1  — when 0, no new grant is captured; a held grant is unaffected.
- `flush`  in  1  — drops any held grant next cycle; pointer is not changed.
- `grant_valid`  out  1  — registered; a grant is held.
- `grant_wfid`  out  6  — registered; winning wavefront id, 0..39.
- `grant_ready`  in  1  — issue stage accepts; accept = `grant_valid & grant_ready`.

## Operation
- State:
  - `last_ptr[5:0]`, reset to (`START_WF` + 39) mod 40.
  - `grant_valid`, reset to 0.
  - `grant_wfid`, reset to 0.
- Start index: `start` = (`last_ptr` + 1) mod 40. 39 wraps to 0.
- Masking: `req_m` = `wf_ready` with bit `grant_wfid` cleared in the accept cycle. This prevents a re-grant before upstream drops the bit; upstream clears it one cycle after accept.
- Rotation: `rot[i]` = `req_m[(i + start) mod 40]` for i = 0..39.
- Encoding: `rot` goes to the encoder with `enable` = `arb_enable`, giving `idx` and `enc_valid`.
- Id recovery: `wfid_n` = `idx + start`, computed as a 7-bit sum. If the sum is ≥ 40, subtract 40.
- Capture condition: (`!grant_valid` | accept) & `!flush` & `enc_valid`.
  - On capture: `grant_valid` ← 1, `grant_wfid` ← `wfid_n`.
  - Otherwise, if accept or `flush`: `grant_valid` ← 0.
  - Otherwise: hold.
- Pointer update: on accept, `last_ptr` ← `grant_wfid`. This happens only on accept; flush and un-accepted grants never move it.
- Held grant: `grant_wfid` stays stable while `grant_valid & !grant_ready`, even if `wf_ready` for that bit drops. Only `flush` withdraws it.
- Simultaneous flush and accept: the accept counts and the pointer updates. `grant_valid` ← 0, and nothing is captured that cycle.
- All-zero `req_m`: no capture; `grant_valid` falls or stays 0.
- `grant_wfid` keeps its last value when `grant_valid` = 0. Consumers ignore it then.
- Reset mid-operation: all state returns to reset values on the next edge. A held grant is lost without being accepted.

## Timing
- Latency: `wf_ready` sampled in cycle N → `grant_valid`/`grant_wfid` visible in N+1.
- Throughput: one grant per cycle with `grant_ready` held high (back-to-back capture on accept).
- Combinational path: mask → rotate → encode → mod-40 add, inside one cycle. No output depends combinationally on any input.
- `grant_ready` may be asserted without `grant_valid`; it has no effect then.

## Configuration
- Macro: `WF_RR_ARBITER_ROUND_ROBIN_EN`.
- Defined: rotating priority as described.
- Undefined:
  - `start` is tied to 0 and `last_ptr` is removed, so the grant goes to the lowest-index ready wavefront.
  - The accept-cycle mask still applies.
  - `START_WF` is ignored.

## Structure
- Shared package holds:
  - `NUM_WF` = 40.
  - `WFID_W` = 6.
  - A `wfid_t` typedef (6-bit).
  - A mod-40 increment/add helper function.
- One sub-module instance: `priority_encoder_40to6`, fed with the rotated vector. Its `valid` output drives `enc_valid`.
- Rotation is a generate loop; there are no other sub-modules.

## Test plan
- Reset, then `wf_ready`=0x00_0000_0005 with `grant_ready`=1 → grants 0 then 2 on consecutive cycles. After each accept, upstream clears the granted bit one cycle later; no duplicate grant occurs.
- All 40 bits set, `grant_ready`=1 for 45 cycles → wfid sequence 0,1,…,39,0,1,…, wrapping 39→0.
- Grant wfid 7 with `grant_ready`=0 for 5 cycles while `wf_ready` changes → `grant_wfid` stays 7 and `grant_valid` stays 1. Then accept → next grant comes from slot 8 onward.
- `flush` together with accept of wfid 12 → `grant_valid`=0 next cycle; the next grant searches from 13.
- `arb_enable`=0 with requests pending → no grant. Re-enable → grant next cycle. Reset mid-hold → `grant_valid`=0, pointer back to `START_WF`.
- Macro undefined, `wf_ready` bits 3 and 30 set, continuous accept, upstream not clearing → grants alternate 3,30,3,30. This is because the mask excludes only the just-accepted id.
